// File: rtl/alu_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_if
//  Description : Request/response bundle between the core control FSM and the
//                sequential ALU.
//                  start   - request strobe; operands sampled when accepted
//                  Control - 4-bit operation select
//                  A, B    - operands
//                  busy    - operation in progress; start ignored while high
//                  done    - one-cycle completion pulse
//                  Result  - registered result, held until the next done
//                  Zero    - registered (Result == 0)
//                master drives the request side; slave is the ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [3:0]            Control;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] Result;
    logic                  Zero;

    modport master (
        output start, Control, A, B,
        input  busy, done, Result, Zero
    );

    modport slave (
        input  start, Control, A, B,
        output busy, done, Result, Zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq
//  Description : Sequential ALU with start/busy/done handshake.
//                Single-cycle ops: add, sub, and, or, xor, sll, slt, srl,
//                sra, sltu. Iterative ops (MDU_ENABLE=1): mul, mulhu via a
//                shift-add multiplier, divu/remu/div/rem via a restoring
//                divider. Division by zero and signed overflow resolve in
//                one cycle with RISC-V results.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - alu_seq_if.slave (start, Control, A, B in;
//                        busy, done, Result, Zero out)
//  Parameters  : DATA_WIDTH - operand width, power of two, >= 4
//                MDU_ENABLE - 1: mul/div hardware present;
//                             0: opcodes 2, 11-15 return 0 in one cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int MDU_ENABLE = 1
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    alu_seq_if.slave   bus
);

    localparam int                        c_shw  = $clog2(DATA_WIDTH);
    localparam logic [c_shw-1:0]          c_last = c_shw'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0]     c_ones = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0]     c_min  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic                      c_mdu  = (MDU_ENABLE != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    // Shared 2W-bit accumulator: MUL keeps {partial product, multiplier},
    // DIV keeps {partial remainder, dividend/quotient}.
    logic [2*DATA_WIDTH-1:0]    r_acc;
    logic [DATA_WIDTH-1:0]      r_opd;      // multiplicand (MUL) or divisor magnitude (DIV)
    logic [c_shw-1:0]           r_cnt;
    logic [3:0]                 r_op;
    logic                       r_neg_q;
    logic                       r_neg_r;
    logic [DATA_WIDTH-1:0]      r_result;
    logic                       r_zero;

    logic                       w_accept;
    logic                       w_last;
    logic [c_shw-1:0]           w_sh;
    logic [DATA_WIDTH-1:0]      w_single;
    logic                       w_div_op;
    logic                       w_signed_div;
    logic                       w_div_zero;
    logic                       w_div_ovf;
    logic                       w_div_special;
    logic [DATA_WIDTH-1:0]      w_special_val;
    logic                       w_is_mul;
    logic                       w_is_div;
    logic [DATA_WIDTH-1:0]      w_imm_res;
    logic                       w_a_neg;
    logic                       w_b_neg;
    logic [DATA_WIDTH-1:0]      w_abs_a;
    logic [DATA_WIDTH-1:0]      w_abs_b;

    logic [DATA_WIDTH:0]        w_mul_sum;
    logic [2*DATA_WIDTH-1:0]    w_mul_next;
    logic [DATA_WIDTH-1:0]      w_mul_res;
    logic [DATA_WIDTH:0]        w_div_trial;
    logic [DATA_WIDTH:0]        w_div_diff;
    logic [2*DATA_WIDTH-1:0]    w_div_next;
    logic [DATA_WIDTH-1:0]      w_q;
    logic [DATA_WIDTH-1:0]      w_r;
    logic [DATA_WIDTH-1:0]      w_div_res;

    // ------------------------------------------------------------------
    // Request decode and single-cycle datapath
    // ------------------------------------------------------------------
    // FIN is not busy, so a new request can be taken back-to-back.
    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_FIN));
    assign w_last   = (r_cnt == c_last);

    always_comb begin
        w_sh     = bus.B[c_shw-1:0];
        w_single = '0;
        unique case (bus.Control)
            4'd0:    w_single = bus.A + bus.B;
            4'd1:    w_single = bus.A - bus.B;
            4'd3:    w_single = bus.A & bus.B;
            4'd4:    w_single = bus.A | bus.B;
            4'd5:    w_single = bus.A ^ bus.B;
            4'd6:    w_single = bus.A << w_sh;
            4'd7:    w_single = {{(DATA_WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            4'd8:    w_single = bus.A >> w_sh;
            4'd9:    w_single = $unsigned($signed(bus.A) >>> w_sh);
            4'd10:   w_single = {{(DATA_WIDTH-1){1'b0}}, (bus.A < bus.B)};
            // MDU opcodes land here only when the MDU is absent
            default: w_single = '0;
        endcase
    end

    always_comb begin
        w_div_op      = c_mdu && (bus.Control >= 4'd12);
        w_signed_div  = bus.Control[1];                 // 14, 15
        w_div_zero    = (bus.B == '0);
        w_div_ovf     = w_signed_div && (bus.A == c_min) && (bus.B == c_ones);
        w_div_special = w_div_op && (w_div_zero || w_div_ovf);

        // Quotient ops are even (12, 14), remainder ops odd (13, 15)
        w_special_val = '0;
        if (w_div_zero) begin
            w_special_val = bus.Control[0] ? bus.A : c_ones;
        end else begin
            w_special_val = bus.Control[0] ? '0 : bus.A;
        end

        w_is_mul  = c_mdu && ((bus.Control == 4'd2) || (bus.Control == 4'd11));
        w_is_div  = w_div_op && !w_div_special;
        w_imm_res = w_div_special ? w_special_val : w_single;

        w_a_neg   = w_signed_div && bus.A[DATA_WIDTH-1];
        w_b_neg   = w_signed_div && bus.B[DATA_WIDTH-1];
        // -MIN wraps to MIN, which is the correct unsigned magnitude
        w_abs_a   = w_a_neg ? -bus.A : bus.A;
        w_abs_b   = w_b_neg ? -bus.B : bus.B;
    end

    // ------------------------------------------------------------------
    // Iteration datapaths
    // ------------------------------------------------------------------
    always_comb begin
        // Shift-add: add multiplicand into the upper half when the current
        // multiplier LSB is set, then shift the whole accumulator right.
        w_mul_sum  = {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, r_opd};
        w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[DATA_WIDTH-1:1]}
                              : {1'b0, r_acc[2*DATA_WIDTH-1:DATA_WIDTH], r_acc[DATA_WIDTH-1:1]};
        w_mul_res  = (r_op == 4'd2) ? w_mul_next[DATA_WIDTH-1:0]
                                    : w_mul_next[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    always_comb begin
        // Restoring step: shift in next dividend bit, try subtracting the
        // divisor, keep the difference only when it did not borrow.
        w_div_trial = {r_acc[2*DATA_WIDTH-1:DATA_WIDTH], r_acc[DATA_WIDTH-1]};
        w_div_diff  = w_div_trial - {1'b0, r_opd};
        if (w_div_diff[DATA_WIDTH]) begin
            w_div_next = {w_div_trial[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b0};
        end else begin
            w_div_next = {w_div_diff[DATA_WIDTH-1:0], r_acc[DATA_WIDTH-2:0], 1'b1};
        end
        w_q = w_div_next[DATA_WIDTH-1:0];
        w_r = w_div_next[2*DATA_WIDTH-1:DATA_WIDTH];

        // Sign correction applied on the final step so Result is ready with done
        unique case (r_op)
            4'd12:   w_div_res = w_q;
            4'd13:   w_div_res = w_r;
            4'd14:   w_div_res = r_neg_q ? -w_q : w_q;
            default: w_div_res = r_neg_r ? -w_r : w_r;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        unique case (r_state)
            S_IDLE, S_FIN: begin
                bus.done = (r_state == S_FIN);
                if (w_accept) begin
                    if (w_is_mul) begin
                        w_state_nxt = S_MUL;
                    end else if (w_is_div) begin
                        w_state_nxt = S_DIV;
                    end else begin
                        w_state_nxt = S_FIN;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_MUL, S_DIV: begin
                bus.busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_FIN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_opd    <= '0;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE, S_FIN: begin
                    if (w_accept) begin
                        r_op  <= bus.Control;
                        r_cnt <= '0;
                        if (w_is_mul) begin
                            r_acc <= {{DATA_WIDTH{1'b0}}, bus.B};
                            r_opd <= bus.A;
                        end else if (w_is_div) begin
                            r_acc   <= {{DATA_WIDTH{1'b0}}, w_abs_a};
                            r_opd   <= w_abs_b;
                            r_neg_q <= w_a_neg ^ w_b_neg;
                            r_neg_r <= w_a_neg;
                        end else begin
                            r_result <= w_imm_res;
                            r_zero   <= (w_imm_res == '0);
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_mul_res;
                        r_zero   <= (w_mul_res == '0);
                    end
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= w_div_res;
                        r_zero   <= (w_div_res == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Result = r_result;
    assign bus.Zero   = r_zero;

endmodule
`default_nettype wire

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised sequential ALU for the multicycle RISC-V core; successor to the combinational ALU.
- Keeps the legacy opcodes 0-8 and adds arithmetic shift, unsigned compare, high-word multiply and iterative divide/remainder.
- Uses a start/busy/done handshake so the control FSM can stall on long operations.
- Result and Zero are registered.

Parameters:
- DATA_WIDTH, 32: operand/result width; must be >=4 and a power of two.
- MDU_ENABLE, 1: 1 = iterative mul/div hardware present; 0 = opcodes 2 and 11-15 return 0 with single-cycle latency.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; A, B, Control sampled on the rising edge where start=1 and busy=0
- Control  in  4  operation select
- A  in  DATA_WIDTH  operand A
- B  in  DATA_WIDTH  operand B
- busy  out  1  high while an operation is in progress; start is ignored while high
- done  out  1  one-cycle pulse; Result and Zero are valid from this cycle
- Result  out  DATA_WIDTH  registered result; held until the next done
- Zero  out  1  registered (Result==0), updated together with Result

Behaviour:
- Reset (async, rst_n=0):
  - Result=0, Zero=1, busy=0, done=0.
  - FSM goes to IDLE and internal accumulators/counter clear.
  - An operation in progress is discarded; no done pulse is issued for it.
- Opcodes (W=DATA_WIDTH, sh=B[log2(W)-1:0]):
  - 0 add; 1 sub; 2 mul low W bits; 3 and; 4 or; 5 xor.
  - 6 sll by sh; 7 slt signed; 8 srl by sh; 9 sra by sh; 10 sltu.
  - 11 mulhu (upper W bits of unsigned A*B).
  - 12 divu; 13 remu; 14 div signed; 15 rem signed.
  - All sums wrap mod 2^W. slt/sltu return 1 or 0.
- FSM states: IDLE, MUL, DIV, FIN.
- IDLE:
  - On an accepted start with opcode 0,1,3-10 (or an MDU opcode when MDU_ENABLE=0), compute, register Result and go to FIN.
  - Opcode 2 or 11 goes to MUL. Opcodes 12-15 go to DIV.
  - Exception: the division special cases below go straight to FIN.
- MUL (shift-add):
  - Unsigned W-bit x W-bit product over exactly W iterations, one per cycle, into a 2W-bit accumulator.
  - Then go to FIN with Result = low half (op 2) or high half (op 11).
- DIV (restoring, unsigned core):
  - Signed ops take operand magnitudes and record the sign.
  - W iterations, one per cycle. In FIN, correct signs: quotient negative iff signs differ; remainder takes the sign of A.
- Division special cases (RISC-V semantics), resolved in one cycle:
  - B==0: quotient = all ones, remainder = A (signed and unsigned).
  - Signed overflow, A = most-negative and B = -1: quotient = A, remainder = 0.
- FIN: done=1 for exactly one cycle, then IDLE. busy=0 in FIN.
- busy: high from the cycle after start acceptance until FIN.
- Latency from the accepting edge to done:
  - Single-cycle ops: 1 cycle.
  - MUL/DIV: W+1 cycles (W iterations plus FIN).
- start:
  - A start asserted in FIN is accepted (back-to-back); done for the new op follows the latency rule above.
  - start while busy=1 is ignored.
- A, B and Control may change freely after acceptance; the operation uses the sampled copies.
- Result/Zero change only at the edge producing done.

Test Plan:
- Reset mid-divide: start divu 100/7, assert rst_n=0 at iteration 10 -> Result=0, Zero=1, busy=0, no done; the next add 2+3 gives Result=5, done 1 cycle after start.
- Single-cycle ops: sub 5-7 -> 0xFFFFFFFE; sra 0x80000000 by B=0x24 (sh=4) -> 0xF8000000; sltu 1 vs 0xFFFFFFFF -> 1; slt 1 vs 0xFFFFFFFF -> 0.
- Multiply (W=32): mul 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; mulhu of the same operands -> 0xFFFFFFFE; done exactly 33 cycles after start; busy high for 32 cycles.
- Signed division: div -7/2 -> 0xFFFFFFFD (-3); rem -7/2 -> 0xFFFFFFFF (-1); divu 100/7 -> 14; remu 100/7 -> 2.
- Division special cases: divu 5/0 -> 0xFFFFFFFF; rem 5/0 -> 5; div 0x80000000/0xFFFFFFFF -> 0x80000000; rem of the same operands -> 0, Zero=1; each done 1 cycle after start.
- Handshake: start held high during a mul -> only one op accepted; new start in the FIN cycle accepted and Result updated on its own done; MDU_ENABLE=0 with div -> Result=0, 1-cycle latency; DATA_WIDTH=8 mul 15*17 -> 0xFF, done 9 cycles after start.
